// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and defaults for the repeated-addition multiplier
package mul_pkg;

  localparam int          W_DEF        = 16;
  localparam logic [15:0] MAX_ITER_DEF = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ADD    = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/mul_iter_cnt.sv
// rtl/mul_iter_cnt.sv - add counter with clear, enable and iteration-limit compare
module mul_iter_cnt #(
  parameter int             W        = 16,
  parameter logic [W-1:0]   MAX_ITER = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  logic [W-1:0] cnt_inc;

  assign cnt_inc = cnt + W'(1);
  // Flags that the add in progress is the last one allowed.
  assign at_limit = (cnt_inc == MAX_ITER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt_inc;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencing FSM driving the multiplier datapath strobes
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int           W        = W_DEF,
  parameter logic [W-1:0] MAX_ITER = W'(MAX_ITER_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         eqz,
  output logic         lda,
  output logic         ldb,
  output logic         clrp,
  output logic         ldp,
  output logic         decb,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] iter_cnt
);

  state_t state, state_nxt;
  logic   cnt_clr, cnt_en, at_limit, err_set, err_clr;

  mul_iter_cnt #(.W(W), .MAX_ITER(MAX_ITER)) u_iter_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .cnt      (iter_cnt),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err <= 1'b0;
    else if (err_clr)
      err <= 1'b0;
    else if (err_set)
      err <= 1'b1;
  end

  always_comb begin
    state_nxt = state;
    lda       = 1'b0;
    ldb       = 1'b0;
    clrp      = 1'b0;
    ldp       = 1'b0;
    decb      = 1'b0;
    done      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start)
          state_nxt = LOAD_A;
      end
      LOAD_A: begin
        lda = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOAD_B;
          cnt_clr   = 1'b1;
          err_clr   = 1'b1;
        end
      end
      LOAD_B: begin
        ldb       = 1'b1;
        clrp      = 1'b1;
        state_nxt = abort ? IDLE : ADD;
      end
      ADD: begin
        // The add strobes follow eqz directly, so an abort cycle still counts its add.
        ldp    = !eqz;
        decb   = !eqz;
        cnt_en = !eqz;
        if (abort) begin
          state_nxt = IDLE;
        end else if (eqz) begin
          state_nxt = DONE;
        end else if (at_limit) begin
          state_nxt = DONE;
          err_set   = 1'b1;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
